// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCM DRP reconfiguration controller.
// State codes, result codes, register address table and preserve masks.
package mmcm_drp_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_RST_ON  = 4'd1;
  localparam state_t S_RD1     = 4'd2;
  localparam state_t S_WRD1    = 4'd3;
  localparam state_t S_WR1     = 4'd4;
  localparam state_t S_WWR1    = 4'd5;
  localparam state_t S_RD2     = 4'd6;
  localparam state_t S_WRD2    = 4'd7;
  localparam state_t S_WR2     = 4'd8;
  localparam state_t S_WWR2    = 4'd9;
  localparam state_t S_RST_OFF = 4'd10;
  localparam state_t S_WLOCK   = 4'd11;
  localparam state_t S_DONE    = 4'd12;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_REQ  = 2'd1;
  localparam logic [1:0] ERR_DRDY = 2'd2;
  localparam logic [1:0] ERR_LOCK = 2'd3;

  // bits of REG1/REG2 that a read-modify-write leaves untouched
  localparam logic [15:0] REG1_KEEP = 16'hF000;
  localparam logic [15:0] REG2_KEEP = 16'hFF3F;

  // power-up divides, channel 0 in the low bits
  localparam logic [48:0] DIV_INIT_ALL = {
    7'd0, 7'd0, 7'd7, 7'd8, 7'd9, 7'd10, 7'd10
  };

  function automatic logic [6:0] reg1_addr(input logic [2:0] ch);
    logic [6:0] a;
    unique case (ch)
      3'd0:    a = 7'h08;
      3'd1:    a = 7'h0A;
      3'd2:    a = 7'h0C;
      3'd3:    a = 7'h0E;
      3'd4:    a = 7'h10;
      3'd5:    a = 7'h06;
      3'd6:    a = 7'h12;
      default: a = 7'h00;
    endcase
    return a;
  endfunction

  function automatic logic [6:0] reg2_addr(input logic [2:0] ch);
    return reg1_addr(ch) | 7'h01;
  endfunction

endpackage

// File: rtl/mmcm_drp_ctrl_div_enc.sv
// Integer divide to MMCM high/low/edge/no_count encoding.
// Pure combinational; divide 1 bypasses the counter, 64 wraps to zero.
module mmcm_div_enc (
  input  logic [6:0] div,
  output logic [5:0] high,
  output logic [5:0] low,
  output logic       edge_sel,
  output logic       no_count
);

  // split the divide into high/low halves, low takes the odd cycle
  always_comb begin
    high     = div[6:1];
    low      = div[6:1] + {5'd0, div[0]};
    edge_sel = div[0];
    no_count = 1'b0;
    unique case (1'b1)
      (div == 7'd1): begin
        high     = 6'd1;
        low      = 6'd1;
        edge_sel = 1'b0;
        no_count = 1'b1;
      end
      (div == 7'd64): begin
        high = 6'd0;
        low  = 6'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// MMCM output-divide reconfiguration over DRP.
// Holds MMCM in reset, RMWs REG1/REG2 of one channel, waits for lock.
module mmcm_drp_ctrl
  import mmcm_drp_pkg::*;
#(
  parameter int NUM_CLK      = 5,
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter logic [7*NUM_CLK-1:0] CUR_DIV_INIT =
    DIV_INIT_ALL[7*NUM_CLK-1:0]
) (
  input  logic                 CLK_IN1,
  input  logic                 RSTN,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_chan,
  input  logic [6:0]           req_div,
  output logic                 rsp_done,
  output logic [1:0]           rsp_err,
  output logic [7*NUM_CLK-1:0] cur_div,
  output logic [6:0]           DADDR,
  output logic [15:0]          DI,
  output logic                 DEN,
  output logic                 DWE,
  input  logic [15:0]          DO,
  input  logic                 DRDY,
  output logic                 MMCM_RST,
  input  logic                 MMCM_LOCKED
);

  localparam logic [15:0] DRP_LIM  = 16'(DRP_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LIM = 16'(LOCK_TIMEOUT - 1);

  state_t                 state_q;
  logic [15:0]            cnt_q;
  logic [2:0]             chan_q;
  logic [6:0]             div_q;
  logic [15:0]            rd1_q;
  logic [15:0]            rd2_q;
  logic [1:0]             err_q;
  logic                   alive_q;
  logic [7*NUM_CLK-1:0]   cur_q;
  logic [5:0]             high;
  logic [5:0]             low;
  logic                   edge_sel;
  logic                   no_count;
  logic                   bad_req;

  mmcm_div_enc u_enc (
    .div      (div_q),
    .high     (high),
    .low      (low),
    .edge_sel (edge_sel),
    .no_count (no_count)
  );

  assign bad_req = (int'(req_chan) >= NUM_CLK)
                 || (req_div == 7'd0)
                 || (req_div > 7'd64);

  assign req_ready = alive_q && (state_q == S_IDLE);
  assign rsp_done  = (state_q == S_DONE);
  assign rsp_err   = err_q;
  assign cur_div   = cur_q;
  assign MMCM_RST  = (state_q >= S_RST_ON) && (state_q <= S_WWR2);

  // sequencer: accept, reset MMCM, two RMW accesses, release, wait lock
  always_ff @(posedge CLK_IN1 or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      div_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      err_q   <= ERR_OK;
      alive_q <= 1'b0;
      cur_q   <= CUR_DIV_INIT;
    end else begin
      alive_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && alive_q) begin
            chan_q  <= req_chan;
            div_q   <= req_div;
            err_q   <= bad_req ? ERR_REQ : ERR_OK;
            state_q <= bad_req ? S_DONE : S_RST_ON;
          end
        end
        S_RST_ON: state_q <= S_RD1;
        S_RD1, S_WR1, S_RD2, S_WR2: begin
          cnt_q   <= '0;
          state_q <= state_q + 4'd1;
        end
        S_WRD1, S_WWR1, S_WRD2, S_WWR2: begin
          if (DRDY) begin
            if (state_q == S_WRD1) rd1_q <= DO;
            if (state_q == S_WRD2) rd2_q <= DO;
            state_q <= state_q + 4'd1;
          end else if (cnt_q == DRP_LIM) begin
            err_q   <= ERR_DRDY;
            state_q <= S_RST_OFF;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RST_OFF: begin
          cnt_q   <= '0;
          state_q <= S_WLOCK;
        end
        S_WLOCK: begin
          if (MMCM_LOCKED || cnt_q == LOCK_LIM) begin
            state_q <= S_DONE;
            if (err_q != ERR_DRDY) begin
              if (!MMCM_LOCKED) err_q <= ERR_LOCK;
              for (int i = 0; i < NUM_CLK; i++) begin
                if (chan_q == 3'(i)) cur_q[7*i +: 7] <= div_q;
              end
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // DRP strobes: one-cycle access from each read/write issue state
  always_comb begin
    DEN   = 1'b0;
    DWE   = 1'b0;
    DADDR = '0;
    DI    = '0;
    unique case (1'b1)
      (state_q == S_RD1): begin
        DEN   = 1'b1;
        DADDR = reg1_addr(chan_q);
      end
      (state_q == S_WR1): begin
        DEN   = 1'b1;
        DWE   = 1'b1;
        DADDR = reg1_addr(chan_q);
        DI    = (rd1_q & REG1_KEEP) | {4'd0, high, low};
      end
      (state_q == S_RD2): begin
        DEN   = 1'b1;
        DADDR = reg2_addr(chan_q);
      end
      (state_q == S_WR2): begin
        DEN   = 1'b1;
        DWE   = 1'b1;
        DADDR = reg2_addr(chan_q);
        DI    = (rd2_q & REG2_KEEP)
              | {8'd0, edge_sel, no_count, 6'd0};
      end
      default: ;
    endcase
  end

endmodule
